// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multicycle CPU controller: opcodes, ALU/mux select
// codes, FSM state encoding and opcode classes.
package cpu_defs_pkg;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_AND  = 6'b000011;
  localparam logic [5:0] OP_OR   = 6'b000100;
  localparam logic [5:0] OP_XOR  = 6'b000101;
  localparam logic [5:0] OP_SLT  = 6'b000110;
  localparam logic [5:0] OP_ADDI = 6'b000111;
  localparam logic [5:0] OP_ANDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001001;
  localparam logic [5:0] OP_LW   = 6'b001010;
  localparam logic [5:0] OP_SW   = 6'b001011;
  localparam logic [5:0] OP_BEQ  = 6'b001100;
  localparam logic [5:0] OP_BNE  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b001110;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;

  localparam logic [1:0] ASB_B   = 2'b00;
  localparam logic [1:0] ASB_ONE = 2'b01;
  localparam logic [1:0] ASB_SE  = 2'b10;
  localparam logic [1:0] ASB_ZE  = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_SEIMM  = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALU_WB, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_BRANCH, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_RALU, CLS_IALU_SE, CLS_IALU_ZE, CLS_LW,
    CLS_SW, CLS_BR, CLS_J, CLS_HALT, CLS_ILL
  } op_class_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decoder: classifies the opcode and picks its ALU operation.
module opcode_decoder
  import cpu_defs_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class,
  output logic [3:0] alu_op,
  output logic       br_ne
);

  always_comb begin
    op_class = CLS_ILL;
    alu_op   = ALU_ADD;
    br_ne    = 1'b0;
    case (opcode)
      OP_NOP:  op_class = CLS_NOP;
      OP_ADD:  begin op_class = CLS_RALU; alu_op = ALU_ADD; end
      OP_SUB:  begin op_class = CLS_RALU; alu_op = ALU_SUB; end
      OP_AND:  begin op_class = CLS_RALU; alu_op = ALU_AND; end
      OP_OR:   begin op_class = CLS_RALU; alu_op = ALU_OR;  end
      OP_XOR:  begin op_class = CLS_RALU; alu_op = ALU_XOR; end
      OP_SLT:  begin op_class = CLS_RALU; alu_op = ALU_SLT; end
      OP_ADDI: begin op_class = CLS_IALU_SE; alu_op = ALU_ADD; end
      OP_ANDI: begin op_class = CLS_IALU_ZE; alu_op = ALU_AND; end
      OP_ORI:  begin op_class = CLS_IALU_ZE; alu_op = ALU_OR;  end
      OP_LW:   op_class = CLS_LW;
      OP_SW:   op_class = CLS_SW;
      OP_BEQ:  op_class = CLS_BR;
      OP_BNE:  begin op_class = CLS_BR; br_ne = 1'b1; end
      OP_J:    op_class = CLS_J;
      OP_HALT: op_class = CLS_HALT;
      default: op_class = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multicycle control FSM for the CPU datapath (Moore outputs).
// Optional CPU_CTRL_ILLEGAL_TRAP_EN: undefined opcodes halt and raise illegal_op.
module cpu_controller
  import cpu_defs_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IReg_out,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        BranchType,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUOp,
  output logic        halted
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic        illegal_op
`endif
);

  state_t     state, state_next;
  op_class_t  dec_class, cls_q;
  logic [3:0] dec_alu_op, alu_op_q;
  logic       dec_br_ne, br_ne_q;
  logic       pc_inc;
  logic       unused_ir_bits;

  assign unused_ir_bits = ^IReg_out[25:0];

  opcode_decoder u_dec (
    .opcode   (IReg_out[31:26]),
    .op_class (dec_class),
    .alu_op   (dec_alu_op),
    .br_ne    (dec_br_ne)
  );

  // DECODE drives outputs from the live IR; later states use the class captured here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      cls_q    <= CLS_NOP;
      alu_op_q <= ALU_ADD;
      br_ne_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        cls_q    <= dec_class;
        alu_op_q <= dec_alu_op;
        br_ne_q  <= dec_br_ne;
      end
    end
  end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      illegal_op <= 1'b0;
    else if (state == S_DECODE && dec_class == CLS_ILL)
      illegal_op <= 1'b1;
  end
`endif

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (dec_class)
          CLS_HALT:                          state_next = S_HALT;
          CLS_RALU, CLS_IALU_SE, CLS_IALU_ZE: state_next = S_EXEC;
          CLS_LW:                            state_next = S_MEM_RD;
          CLS_SW:                            state_next = S_MEM_WR;
          CLS_BR:                            state_next = S_BRANCH;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
          CLS_ILL:                           state_next = S_HALT;
`endif
          default:                           state_next = S_FETCH;
        endcase
      end
      S_EXEC:   state_next = S_ALU_WB;
      S_MEM_RD: state_next = S_MEM_WB;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    BranchType  = 1'b0;
    PCSource    = PCS_ALU;
    ALUSrcB     = ASB_B;
    ALUOp       = ALU_ADD;
    halted      = 1'b0;
    pc_inc      = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
      end
      S_DECODE: begin
        case (dec_class)
          CLS_NOP: pc_inc = 1'b1;
          CLS_J: begin
            PCWrite  = 1'b1;
            PCSource = PCS_JUMP;
          end
`ifndef CPU_CTRL_ILLEGAL_TRAP_EN
          CLS_ILL: pc_inc = 1'b1;
`endif
          default: ;
        endcase
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = alu_op_q;
        case (cls_q)
          CLS_IALU_SE: ALUSrcB = ASB_SE;
          CLS_IALU_ZE: ALUSrcB = ASB_ZE;
          default:     ALUSrcB = ASB_B;
        endcase
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        pc_inc   = 1'b1;
      end
      S_MEM_RD: MemRead = 1'b1;
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        pc_inc   = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        pc_inc   = 1'b1;
      end
      S_BRANCH: begin
        PCWriteCond = 1'b1;
        BranchType  = br_ne_q;
        pc_inc      = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    // PC+1 overlays the ALU operand selects; EXEC never requests it, so no conflict.
    if (pc_inc) begin
      PCWrite  = 1'b1;
      ALUSrcA  = 1'b0;
      ALUSrcB  = ASB_ONE;
      ALUOp    = ALU_ADD;
      PCSource = PCS_ALU;
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: vector table, random program against
// a per-cycle reference model, and hand-written reset/halt/illegal sequences.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IReg_out;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic        ALUSrcA, RegWrite, RegDst, BranchType, halted;
  logic [1:0]  PCSource, ALUSrcB;
  logic [3:0]  ALUOp;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  logic        illegal_op;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  cpu_controller dut (
    .clk         (clk),
    .reset       (reset),
    .IReg_out    (IReg_out),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .ALUSrcA     (ALUSrcA),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .BranchType  (BranchType),
    .PCSource    (PCSource),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .halted      (halted)
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_op  (illegal_op)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, bt;
    logic [1:0] pcs, asb;
    logic [3:0] aop;
    logic       hlt;
  } ctl_t;

  typedef struct {
    logic [5:0]  op;
    int unsigned c;
    ctl_t        exp;
  } vec_t;

  ctl_t got;
  assign got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                ALUSrcA, RegWrite, RegDst, BranchType, PCSource, ALUSrcB, ALUOp, halted};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input ctl_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%05h exp=%05h", name, got, exp);
    end
  endtask

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  task automatic check_ill(input string name, input logic exp);
    total++;
    if (illegal_op !== exp) begin
      bad++;
      $display("FAIL %s: illegal_op=%b exp=%b", name, illegal_op, exp);
    end
  endtask
`endif

  function automatic ctl_t mk(input bit pcw, pcwc, mrd, mwr, irw, m2r, asa, rw, bt,
                              input logic [1:0] pcs, asb, input logic [3:0] aop,
                              input bit hlt);
    ctl_t e = '0;
    e.pcw = pcw; e.pcwc = pcwc; e.mrd = mrd; e.mwr = mwr; e.irw = irw;
    e.m2r = m2r; e.asa = asa; e.rw = rw; e.bt = bt;
    e.pcs = pcs; e.asb = asb; e.aop = aop; e.hlt = hlt;
    return e;
  endfunction

  function automatic bit is_undef(input logic [5:0] op);
    return op >= 6'd15 && op <= 6'd62;
  endfunction

  // Reference: cycles per instruction class.
  function automatic int unsigned cpi(input logic [5:0] op);
    if (op == 6'd0 || op == 6'd14) return 2;
    if (op >= 6'd1 && op <= 6'd10) return 4;
    if (op >= 6'd11 && op <= 6'd13) return 3;
    return 2;
  endfunction

  // Reference: expected controls at cycle c (0 = fetch) of instruction op.
  function automatic ctl_t model(input logic [5:0] op, input int unsigned c);
    ctl_t pc1 = mk(1,0,0,0,0,0,0,0,0, 2'b00, 2'b01, 4'h0, 0);
    ctl_t e   = '0;
    logic [5:0] d = op - 6'd1;
    if (c == 0) return mk(0,0,1,0,1,0,0,0,0, 2'b00, 2'b00, 4'h0, 0);
    if (c == 1) begin
      if (op == 6'd0 || (is_undef(op) && !TRAP)) return pc1;
      if (op == 6'd14) return mk(1,0,0,0,0,0,0,0,0, 2'b10, 2'b00, 4'h0, 0);
      return '0;
    end
    if (c == 2) begin
      if (op >= 6'd1 && op <= 6'd6) return mk(0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, d[3:0], 0);
      case (op)
        6'd7:  e = mk(0,0,0,0,0,0,1,0,0, 2'b00, 2'b10, 4'h0, 0);
        6'd8:  e = mk(0,0,0,0,0,0,1,0,0, 2'b00, 2'b11, 4'h2, 0);
        6'd9:  e = mk(0,0,0,0,0,0,1,0,0, 2'b00, 2'b11, 4'h3, 0);
        6'd10: e = mk(0,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 4'h0, 0);
        6'd11: begin e = pc1; e.mwr = 1'b1; end
        6'd12, 6'd13: begin e = pc1; e.pcwc = 1'b1; e.bt = op[0]; end
        default: e = '0;
      endcase
      return e;
    end
    if (c == 3) begin
      e = pc1;
      e.rw = 1'b1;
      if (op == 6'd10) e.m2r = 1'b1;
      return e;
    end
    return '0;
  endfunction

  // Starts at a negedge inside FETCH and ends at the negedge of the next FETCH.
  task automatic run_instr(input logic [5:0] op, input int unsigned chk_c,
                           input ctl_t chk_exp, input string name);
    logic [31:0] r;
    int unsigned n;
    r = $urandom();
    r[31:26] = op;
    IReg_out = r;
    n = cpi(op);
    for (int unsigned c = 0; c < n; c++) begin
      if (c != 0) @(negedge clk);
      check($sformatf("%s op=%0d c%0d", name, op, c), model(op, c));
      if (c == chk_c) check($sformatf("%s vec", name), chk_exp);
    end
    @(negedge clk);
  endtask

  vec_t tab[18];
  ctl_t fetch_v, halt_v;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] op;
    fetch_v = mk(0,0,1,0,1,0,0,0,0, 2'b00, 2'b00, 4'h0, 0);
    halt_v  = mk(0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 4'h0, 1);
    tab[0]  = '{6'd0,  1, mk(1,0,0,0,0,0,0,0,0, 2'b00, 2'b01, 4'h0, 0)};
    tab[1]  = '{6'd1,  2, mk(0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 4'h0, 0)};
    tab[2]  = '{6'd1,  3, mk(1,0,0,0,0,0,0,1,0, 2'b00, 2'b01, 4'h0, 0)};
    tab[3]  = '{6'd2,  2, mk(0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 4'h1, 0)};
    tab[4]  = '{6'd3,  2, mk(0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 4'h2, 0)};
    tab[5]  = '{6'd4,  2, mk(0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 4'h3, 0)};
    tab[6]  = '{6'd5,  2, mk(0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 4'h4, 0)};
    tab[7]  = '{6'd6,  2, mk(0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 4'h5, 0)};
    tab[8]  = '{6'd7,  2, mk(0,0,0,0,0,0,1,0,0, 2'b00, 2'b10, 4'h0, 0)};
    tab[9]  = '{6'd8,  2, mk(0,0,0,0,0,0,1,0,0, 2'b00, 2'b11, 4'h2, 0)};
    tab[10] = '{6'd9,  2, mk(0,0,0,0,0,0,1,0,0, 2'b00, 2'b11, 4'h3, 0)};
    tab[11] = '{6'd10, 2, mk(0,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 4'h0, 0)};
    tab[12] = '{6'd10, 3, mk(1,0,0,0,0,1,0,1,0, 2'b00, 2'b01, 4'h0, 0)};
    tab[13] = '{6'd11, 2, mk(1,0,0,1,0,0,0,0,0, 2'b00, 2'b01, 4'h0, 0)};
    tab[14] = '{6'd12, 2, mk(1,1,0,0,0,0,0,0,0, 2'b00, 2'b01, 4'h0, 0)};
    tab[15] = '{6'd13, 2, mk(1,1,0,0,0,0,0,0,1, 2'b00, 2'b01, 4'h0, 0)};
    tab[16] = '{6'd14, 1, mk(1,0,0,0,0,0,0,0,0, 2'b10, 2'b00, 4'h0, 0)};
    tab[17] = '{6'd11, 1, '0};

    // Reset held three cycles with NOP in IR.
    reset    = 1'b1;
    IReg_out = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset", fetch_v);
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      check_ill("reset ill", 1'b0);
`endif
    end
    reset = 1'b0;

    for (int unsigned i = 0; i < 3; i++) run_instr(6'd0, 99, '0, "nop");

    for (int unsigned i = 0; i < 18; i++)
      run_instr(tab[i].op, tab[i].c, tab[i].exp, $sformatf("tab%0d", i));

    for (int unsigned i = 0; i < 200; i++) begin
      op = 6'($urandom_range(0, 62));
      if (TRAP && is_undef(op)) op = 6'($urandom_range(0, 14));
      run_instr(op, 99, '0, "rand");
    end

    // HALT, ten idle cycles, then an asynchronous reset pulse.
    IReg_out = 32'hFC00_0000;
    check("halt fetch", fetch_v);
    @(negedge clk);
    check("halt decode", '0);
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      check("halt idle", halt_v);
    end
    #2 reset = 1'b1;
    #1 check("halt async reset", fetch_v);
    @(negedge clk);
    reset = 1'b0;
    run_instr(6'd0, 99, '0, "post halt");

    // Reset in EXEC of an ADD must abandon the instruction.
    IReg_out = {6'd1, 5'd5, 5'd6, 5'd7, 11'd0};
    @(negedge clk);
    @(negedge clk);
    check("midreset exec", model(6'd1, 2));
    reset = 1'b1;
    #1 check("midreset async", fetch_v);
    @(negedge clk);
    check("midreset held", fetch_v);
    reset = 1'b0;
    run_instr(6'd0, 99, '0, "after midreset");
    run_instr(6'd1, 99, '0, "after midreset add");

    // Opcode 010101.
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    IReg_out = {6'b010101, 26'd0};
    check("ill fetch", fetch_v);
    check_ill("ill fetch flag", 1'b0);
    @(negedge clk);
    check("ill decode", '0);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ill halted", halt_v);
      check_ill("ill flag", 1'b1);
    end
    reset = 1'b1;
    #1 check_ill("ill cleared", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    run_instr(6'd0, 99, '0, "post ill");
`else
    run_instr(6'b010101, 1, mk(1,0,0,0,0,0,0,0,0, 2'b00, 2'b01, 4'h0, 0), "undef");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multicycle control FSM driving every control line of the CPU datapath. It decodes the instruction register's opcode (`IReg_out[31:26]`) and sequences fetch, decode, execute, memory and writeback. It is the consumer of `IReg_out` and the producer of all datapath control inputs, and sits beside the datapath at CPU top level.

## Interface
- No parameters; widths fixed by datapath.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `IReg_out` in 32: instruction register contents.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `ALUSrcA`, `RegWrite`, `RegDst`, `BranchType` out 1 each: datapath controls.
- `PCSource` out 2: PC source select (00 ALU, 01 ALUOut, 10 jump, 11 SE(imm)).
- `ALUSrcB` out 2: ALU B select (00 B, 01 const 1, 10 SE, 11 ZE).
- `ALUOp` out 4: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101.
- `halted` out 1: high in HALT.

## Operation
- Opcodes:
  - NOP 000000.
  - ADD/SUB/AND/OR/XOR/SLT 000001–000110: r1 ← r2 op r3.
  - ADDI 000111 (SE), ANDI 001000 (ZE), ORI 001001 (ZE).
  - LW 001010: r1 ← M[imm].
  - SW 001011: M[imm] ← r2.
  - BEQ 001100, BNE 001101: compare r2, r3; target SE(imm).
  - J 001110.
  - HALT 111111.
  - Any other opcode is undefined.
- Moore outputs: functions of state plus latched opcode class. Every output not listed for a state is 0. `IorD` and `RegDst` are always 0.
- "PC+1" means `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=ADD, `PCSource`=00, `PCWrite`=1.
- FETCH: `MemRead`=1, `IRWrite`=1; go to DECODE.
- DECODE (IR valid; A/B load at edge):
  - NOP: PC+1, go to FETCH.
  - J: `PCWrite`=1, `PCSource`=10, go to FETCH.
  - HALT: go to HALT.
  - ALU ops: go to EXEC.
  - LW: go to MEM_RD.
  - SW: go to MEM_WR.
  - BEQ/BNE: go to BRANCH.
- EXEC: `ALUSrcA`=1. `ALUSrcB` is 00 for R ops, 10 for ADDI, 11 for ANDI/ORI. `ALUOp` per opcode. Go to ALU_WB.
- ALU_WB: `RegWrite`=1, `MemtoReg`=0, PC+1; go to FETCH.
- MEM_RD: `MemRead`=1; go to MEM_WB.
- MEM_WB: `RegWrite`=1, `MemtoReg`=1, PC+1; go to FETCH.
- MEM_WR: `MemWrite`=1, PC+1; go to FETCH.
- BRANCH: PC+1, `PCWriteCond`=1, `BranchType`=0 for BEQ and 1 for BNE; go to FETCH.
  - Datapath contract: the branch override is qualified by `PCWriteCond`, which is 0 in every other state.
- HALT: all write enables 0, `halted`=1. Only reset exits.

## Timing
- Reset outputs (state FETCH): `MemRead`=1, `IRWrite`=1, all other outputs 0, `halted`=0.
- Cycles per instruction:
  - NOP, J: 2.
  - SW, BEQ/BNE: 3.
  - ALU ops, LW: 4.
- PC changes only at the last edge of an instruction, so IR stays stable through the whole instruction.
- `RegWrite` and the PC update share one edge. The register file samples the old r1, which is correct.
- Reset asserted mid-instruction: state goes to FETCH immediately; no partial write survives after reset deasserts.
- Undefined opcodes behave as NOP unless trap is enabled.

## Configuration
- `CPU_CTRL_ILLEGAL_TRAP_EN` defined:
  - Adds output `illegal_op` (1 bit, reset 0).
  - An undefined opcode in DECODE goes to HALT and sets `illegal_op`=1, held until reset.
- Macro undefined: no port; undefined opcodes are treated as NOP (PC+1).

## Structure
- Shared package `cpu_defs_pkg` holds:
  - Opcode constants.
  - ALUOp codes.
  - ALUSrcB and PCSource select codes.
  - State encoding (enumerated, 4 bits).
- One sub-module `opcode_decoder`: combinational; maps opcode to class (NOP, RALU, IALU_SE, IALU_ZE, LW, SW, BR, J, HALT, ILL) and ALUOp.

## Test plan
- Reset held 3 cycles, then released with IR=NOP: outputs match reset values; `PCWrite` pulses every 2nd cycle.
- ADD r1=5, r2=6, r3=7: EXEC shows `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=0000; next cycle `RegWrite`=1 and `PCWrite`=1 together; 4 cycles total.
- LW imm=0x0010, then SW: LW shows MEM_RD then MEM_WB with `MemtoReg`=1. SW shows `MemWrite`=1 for exactly one cycle at cycle 3.
- BNE then J 0x0000040: BRANCH shows `PCWriteCond`=1 and `BranchType`=1. J shows `PCSource`=10 in DECODE; 2 cycles.
- HALT then 10 idle cycles: `halted`=1 and no write enables. Reset pulse mid-HALT returns to FETCH.
- Opcode 010101: with the macro, `illegal_op`=1 and `halted`=1. Without the macro, it executes as NOP (PC+1 in DECODE).
